jelly_video_tbl_modulator_ctl: RTL and testbench
================================================

// Module: jelly_video_tbl_modulator_ctl
// PURPOSE
//  Wishbone-master sequencer that programs jelly_video_tbl_modulator: generates an ordered-dither threshold table,
//  writes it plus the END and INV registers over WB, then reports done. Sits between system control and the
//  modulator's s_wb port, replacing hand-written register writes; optionally flips INV every frame.
// PARAMETERS
//  WB_ADR_WIDTH  8   word address width of m_wb_adr_o
//  WB_DAT_WIDTH  32  WB data width; WB_SEL_WIDTH = WB_DAT_WIDTH/8
//  TDATA_WIDTH   8   threshold width, must be <= WB_DAT_WIDTH
//  TBL_BITS      4   log2 of table size; TBL_NUM = 2**TBL_BITS entries max
//  ADR_TBL       'h40  word address of table entry 0 (entry i at ADR_TBL+i)
//  ADR_END       'h04  word address of END register
//  ADR_INV       'h05  word address of INV register
// PORTS
//  clk          in   1             system clock (single clock domain)
//  reset        in   1             synchronous, active-high reset
//  start        in   1             pulse: begin programming sequence
//  param_end    in   TBL_BITS      last table index to write (END value), sampled on accepted start
//  param_inv    in   1             INV value, sampled on accepted start
//  frame_start  in   1             pulse at video frame start (modulator tuser domain, same clk)
//  busy         out  1             sequence in progress
//  done         out  1             one-cycle pulse when a sequence completes
//  m_wb_adr_o   out  WB_ADR_WIDTH  WB word address
//  m_wb_dat_o   out  WB_DAT_WIDTH  WB write data, zero-extended
//  m_wb_we_o    out  1             always 1 while stb
//  m_wb_sel_o   out  WB_SEL_WIDTH  all ones while stb
//  m_wb_stb_o   out  1             WB strobe
//  m_wb_ack_i   in   1             WB acknowledge
// BEHAVIOUR
//  Reset: busy=0, done=0, stb=0, we=0, sel=0, adr=0, dat=0; state IDLE; table index=0; inv_cur=0; pending=0.
//  FSM: IDLE -> TBL (start) -> GAP -> TBL ... -> END -> GAP -> INV -> GAP -> DONE -> IDLE.
//  - IDLE: start accepted only here; latches end_r=param_end, inv_cur=param_inv; busy=1 next cycle.
//  - Each write state drives stb=1 with stable adr/dat until the cycle ack_i=1; stb drops the next cycle
//    (GAP, exactly one idle cycle) before the next write. ack_i while stb=0 is ignored.
//  - TBL entry i (i=0..end_r): dat = bitrev_TBL_BITS(i+1 mod TBL_NUM) << (TDATA_WIDTH-TBL_BITS), i.e. left-aligned;
//    entry for i+1=TBL_NUM wraps to 0. Index increments on ack; after ack of i=end_r go to END.
//  - END write dat=end_r; INV write dat=inv_cur. DONE: done=1 one cycle, busy=0 same cycle.
//  - Minimum duration with zero-wait ack: 2*(end_r+3) cycles from start to done.
//  - start while busy: ignored (no queueing). end_r=0 writes exactly one table entry.
//  - reset mid-transaction: stb drops at next edge; no partial-state recovery, sequence must be restarted.
//  - frame_start without INV_TOGGLE feature: ignored.
// CONFIGURATION
//  JELLY_VIDEO_TBL_MODULATOR_CTL_INV_TOGGLE_EN defined: after first completed sequence, each frame_start
//    (in IDLE) sets inv_cur=~inv_cur and issues a single INV write (INV -> GAP -> DONE, done pulses, table untouched).
//    frame_start during busy sets pending; pending toggle runs immediately after DONE; multiple pulses collapse to one.
//    start and frame_start same cycle in IDLE: start wins, pending set.
//  Not defined: no toggle logic, pending reg absent, frame_start unused.
// STRUCTURE
//  Package jelly_video_tbl_modulator_pkg: state enum, default ADR_TBL/ADR_END/ADR_INV constants, bitrev function.
//  One sub-module natural: jelly_wb_write_master (single-write stb/ack/gap handshake); FSM and table generator top.
// TESTING
//  1 TBL_BITS=4, param_end=14, inv=0, zero-wait ack -> 15 writes adr 0x40..0x4e dat 0x80,0x40,0xc0..0xf0, then
//    adr 0x04 dat 14, adr 0x05 dat 0, done at 2*17 cycles after start.
//  2 ack delayed random 0-5 cycles -> adr/dat stable while stb, exactly one gap cycle per write, same data order.
//  3 param_end=0 -> single table write (0x40 <= 0x80), END=0, INV written; start pulses while busy -> no extra writes.
//  4 reset asserted during 5th table write -> stb=0, busy=0 next cycle; new start re-writes from entry 0.
//  5 INV_TOGGLE_EN, inv=1: after done, frame_start -> one write adr 0x05 dat 0; frame_start x2 while busy -> one
//    toggle write after DONE; without macro frame_start produces no WB traffic.

Source files
------------

// File: rtl/jelly_video_tbl_modulator_pkg.sv
// ---------------------------------------------------------------------------
// jelly_video_tbl_modulator_pkg
//   Shared definitions for the modulator programming sequencer:
//   - state_t      : sequencer FSM states
//   - DEF_ADR_*    : default word addresses of the modulator registers
//   - bitrev()     : reverses the low n bits of a value (ordered-dither order)
// ---------------------------------------------------------------------------
package jelly_video_tbl_modulator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TBL,
        ST_GAP,
        ST_END,
        ST_INV,
        ST_DONE
    } state_t;

    localparam int DEF_ADR_TBL = 'h40;
    localparam int DEF_ADR_END = 'h04;
    localparam int DEF_ADR_INV = 'h05;

    // Bit-reversal of the low n bits of v; bits at and above n come out zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) begin
                r[i] = v[n-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/jelly_wb_write_master.sv
// ---------------------------------------------------------------------------
// jelly_wb_write_master
//   Single-write Wishbone master. A one-cycle 'issue' loads address/data and
//   raises stb; stb, adr and dat stay stable until the cycle ack_i is seen,
//   then stb drops at the next edge. The caller guarantees it only issues
//   while no write is outstanding. ack_i while stb is low is ignored.
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   issue               : start one write with issue_adr / issue_dat
//   wr_ack              : pulse in the cycle the outstanding write completes
//   m_wb_*              : Wishbone master write port
// ---------------------------------------------------------------------------
module jelly_wb_write_master #(
    parameter int ADR_WIDTH = 8,
    parameter int DAT_WIDTH = 32,
    parameter int SEL_WIDTH = DAT_WIDTH / 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue,
    input  logic [ADR_WIDTH-1:0] issue_adr,
    input  logic [DAT_WIDTH-1:0] issue_dat,
    output logic                 wr_ack,
    output logic [ADR_WIDTH-1:0] m_wb_adr_o,
    output logic [DAT_WIDTH-1:0] m_wb_dat_o,
    output logic                 m_wb_we_o,
    output logic [SEL_WIDTH-1:0] m_wb_sel_o,
    output logic                 m_wb_stb_o,
    input  logic                 m_wb_ack_i
);

    logic                 stb_q, stb_d;
    logic [ADR_WIDTH-1:0] adr_q, adr_d;
    logic [DAT_WIDTH-1:0] dat_q, dat_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        stb_d = stb_q;
        adr_d = adr_q;
        dat_d = dat_q;
        if (stb_q && m_wb_ack_i) begin
            stb_d = 1'b0;
        end
        if (issue) begin
            stb_d = 1'b1;
            adr_d = issue_adr;
            dat_d = issue_dat;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            stb_q <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
        end else begin
            stb_q <= stb_d;
            adr_q <= adr_d;
            dat_q <= dat_d;
        end
    end

    assign wr_ack     = stb_q & m_wb_ack_i;
    assign m_wb_adr_o = adr_q;
    assign m_wb_dat_o = dat_q;
    assign m_wb_stb_o = stb_q;
    assign m_wb_we_o  = stb_q;
    assign m_wb_sel_o = {SEL_WIDTH{stb_q}};

endmodule

// File: rtl/jelly_video_tbl_modulator_ctl.sv
// ---------------------------------------------------------------------------
// jelly_video_tbl_modulator_ctl
//   Wishbone-master sequencer that programs jelly_video_tbl_modulator.
//   On an accepted start it writes the ordered-dither threshold table
//   (entries 0..param_end), then the END register, then the INV register,
//   with exactly one idle cycle between writes, and pulses done.
//
//   Optional feature macro: JELLY_VIDEO_TBL_MODULATOR_CTL_INV_TOGGLE_EN
//   When defined, once a first sequence has completed, every frame_start
//   flips INV and issues a single INV write. A frame_start seen while busy
//   is remembered (multiple pulses collapse to one) and serviced right
//   after the running sequence. Without the macro frame_start is unused.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   start               : pulse, begin a programming sequence (IDLE only)
//   param_end, param_inv: END / INV values, sampled on an accepted start
//   frame_start         : video frame start pulse (toggle feature only)
//   busy                : sequence in progress
//   done                : one-cycle pulse when a sequence completes
//   m_wb_*              : Wishbone master port to the modulator s_wb
// ---------------------------------------------------------------------------
module jelly_video_tbl_modulator_ctl
    import jelly_video_tbl_modulator_pkg::*;
#(
    parameter int                      WB_ADR_WIDTH = 8,
    parameter int                      WB_DAT_WIDTH = 32,
    parameter int                      WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
    parameter int                      TDATA_WIDTH  = 8,
    parameter int                      TBL_BITS     = 4,
    parameter logic [WB_ADR_WIDTH-1:0] ADR_TBL      = WB_ADR_WIDTH'(DEF_ADR_TBL),
    parameter logic [WB_ADR_WIDTH-1:0] ADR_END      = WB_ADR_WIDTH'(DEF_ADR_END),
    parameter logic [WB_ADR_WIDTH-1:0] ADR_INV      = WB_ADR_WIDTH'(DEF_ADR_INV)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [TBL_BITS-1:0]     param_end,
    input  logic                    param_inv,
    input  logic                    frame_start,
    output logic                    busy,
    output logic                    done,
    output logic [WB_ADR_WIDTH-1:0] m_wb_adr_o,
    output logic [WB_DAT_WIDTH-1:0] m_wb_dat_o,
    output logic                    m_wb_we_o,
    output logic [WB_SEL_WIDTH-1:0] m_wb_sel_o,
    output logic                    m_wb_stb_o,
    input  logic                    m_wb_ack_i
);

    // Threshold for table entry idx: bit-reversed (idx+1) wrapped to the
    // table size, left-aligned in TDATA_WIDTH, zero-extended to the bus.
    // The TBL_BITS-wide increment provides the wrap of the last entry to 0.
    function automatic logic [WB_DAT_WIDTH-1:0] tbl_word(input logic [TBL_BITS-1:0] idx);
        logic [TBL_BITS-1:0]    nxt;
        logic [TDATA_WIDTH-1:0] thr;
        nxt = idx + TBL_BITS'(1);
        thr = TDATA_WIDTH'(bitrev(32'(nxt), TBL_BITS)) << (TDATA_WIDTH - TBL_BITS);
        return WB_DAT_WIDTH'(thr);
    endfunction

    state_t              state_q, state_d;
    state_t              nxt_q, nxt_d;     // write state the GAP leads into
    logic [TBL_BITS-1:0] idx_q, idx_d;
    logic [TBL_BITS-1:0] end_q, end_d;
    logic                inv_q, inv_d;

    logic                    issue;
    logic [WB_ADR_WIDTH-1:0] issue_adr;
    logic [WB_DAT_WIDTH-1:0] issue_dat;
    logic                    wr_ack;

`ifdef JELLY_VIDEO_TBL_MODULATOR_CTL_INV_TOGGLE_EN
    logic pending_q, pending_d;
    logic inited_q, inited_d;   // a full sequence has completed at least once
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
`endif

    always_comb begin
        state_d   = state_q;
        nxt_d     = nxt_q;
        idx_d     = idx_q;
        end_d     = end_q;
        inv_d     = inv_q;
        issue     = 1'b0;
        issue_adr = '0;
        issue_dat = '0;
`ifdef JELLY_VIDEO_TBL_MODULATOR_CTL_INV_TOGGLE_EN
        pending_d = pending_q;
        inited_d  = inited_q;
        // Any frame_start outside IDLE is remembered; IDLE decides below.
        if (frame_start && state_q != ST_IDLE) begin
            pending_d = 1'b1;
        end
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    end_d     = param_end;
                    inv_d     = param_inv;
                    idx_d     = '0;
                    issue     = 1'b1;
                    issue_adr = ADR_TBL;
                    issue_dat = tbl_word(TBL_BITS'(0));
                    state_d   = ST_TBL;
`ifdef JELLY_VIDEO_TBL_MODULATOR_CTL_INV_TOGGLE_EN
                    if (frame_start) begin
                        pending_d = 1'b1;
                    end
                end else if (pending_q || (frame_start && inited_q)) begin
                    inv_d     = ~inv_q;
                    pending_d = 1'b0;
                    issue     = 1'b1;
                    issue_adr = ADR_INV;
                    issue_dat = WB_DAT_WIDTH'(~inv_q);
                    state_d   = ST_INV;
`endif
                end
            end

            ST_TBL: begin
                if (wr_ack) begin
                    if (idx_q == end_q) begin
                        nxt_d = ST_END;
                    end else begin
                        idx_d = idx_q + TBL_BITS'(1);
                        nxt_d = ST_TBL;
                    end
                    state_d = ST_GAP;
                end
            end

            ST_END: begin
                if (wr_ack) begin
                    nxt_d   = ST_INV;
                    state_d = ST_GAP;
                end
            end

            ST_INV: begin
                if (wr_ack) begin
                    nxt_d   = ST_DONE;
                    state_d = ST_GAP;
                end
            end

            // stb is already low here; launch the following write so it
            // appears on the bus right after this single idle cycle.
            ST_GAP: begin
                state_d = nxt_q;
                case (nxt_q)
                    ST_TBL: begin
                        issue     = 1'b1;
                        issue_adr = ADR_TBL + WB_ADR_WIDTH'(idx_q);
                        issue_dat = tbl_word(idx_q);
                    end
                    ST_END: begin
                        issue     = 1'b1;
                        issue_adr = ADR_END;
                        issue_dat = WB_DAT_WIDTH'(end_q);
                    end
                    ST_INV: begin
                        issue     = 1'b1;
                        issue_adr = ADR_INV;
                        issue_dat = WB_DAT_WIDTH'(inv_q);
                    end
                    default: begin
                    end
                endcase
            end

            ST_DONE: begin
                state_d = ST_IDLE;
`ifdef JELLY_VIDEO_TBL_MODULATOR_CTL_INV_TOGGLE_EN
                inited_d = 1'b1;
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            nxt_q     <= ST_IDLE;
            idx_q     <= '0;
            end_q     <= '0;
            inv_q     <= 1'b0;
`ifdef JELLY_VIDEO_TBL_MODULATOR_CTL_INV_TOGGLE_EN
            pending_q <= 1'b0;
            inited_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            nxt_q     <= nxt_d;
            idx_q     <= idx_d;
            end_q     <= end_d;
            inv_q     <= inv_d;
`ifdef JELLY_VIDEO_TBL_MODULATOR_CTL_INV_TOGGLE_EN
            pending_q <= pending_d;
            inited_q  <= inited_d;
`endif
        end
    end

    assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done = (state_q == ST_DONE);

    jelly_wb_write_master #(
        .ADR_WIDTH (WB_ADR_WIDTH),
        .DAT_WIDTH (WB_DAT_WIDTH),
        .SEL_WIDTH (WB_SEL_WIDTH)
    ) u_wr (
        .clk        (clk),
        .reset      (reset),
        .issue      (issue),
        .issue_adr  (issue_adr),
        .issue_dat  (issue_dat),
        .wr_ack     (wr_ack),
        .m_wb_adr_o (m_wb_adr_o),
        .m_wb_dat_o (m_wb_dat_o),
        .m_wb_we_o  (m_wb_we_o),
        .m_wb_sel_o (m_wb_sel_o),
        .m_wb_stb_o (m_wb_stb_o),
        .m_wb_ack_i (m_wb_ack_i)
    );

endmodule

// File: tb/tb_jelly_video_tbl_modulator_ctl.sv
// ---------------------------------------------------------------------------
// tb_jelly_video_tbl_modulator_ctl
//   Scoreboard bench: stimulus pushes expected WB writes and done pulses
//   into a queue; a negedge monitor pops and compares them as the DUT
//   presents them, and also watches stb stability and the one-cycle gap.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jelly_video_tbl_modulator_ctl;

    typedef struct {
        bit          is_done;
        logic [7:0]  adr;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  param_end;
    logic        param_inv;
    logic        frame_start;
    logic        busy;
    logic        done;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        ack;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   start_cyc = 0;
    int   done_cyc  = 0;
    exp_t q[$];

    // Hand-computed left-aligned bit-reversed thresholds for entries 0..15.
    logic [31:0] exp_tbl [16] = '{32'h80, 32'h40, 32'hc0, 32'h20, 32'ha0, 32'h60, 32'he0, 32'h10,
                                  32'h90, 32'h50, 32'hd0, 32'h30, 32'hb0, 32'h70, 32'hf0, 32'h00};

    // ack driver controls
    bit         rand_mode = 1'b0;
    bit         stall_en  = 1'b0;
    logic [7:0] stall_adr = 8'h00;
    int         dly = 0;

    jelly_video_tbl_modulator_ctl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .param_end   (param_end),
        .param_inv   (param_inv),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done),
        .m_wb_adr_o  (adr),
        .m_wb_dat_o  (dat),
        .m_wb_we_o   (we),
        .m_wb_sel_o  (sel),
        .m_wb_stb_o  (stb),
        .m_wb_ack_i  (ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_w(input logic [7:0] a, input logic [31:0] d);
        exp_t e;
        e.is_done = 1'b0; e.adr = a; e.dat = d;
        q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1; e.adr = '0; e.dat = '0;
        q.push_back(e);
    endtask

    task automatic push_seq(input int end_v, input bit inv_v);
        for (int i = 0; i <= end_v; i++) push_w(8'h40 + 8'(i), exp_tbl[i]);
        push_w(8'h04, 32'(end_v));
        push_w(8'h05, 32'(inv_v));
        push_done();
    endtask

    task automatic do_start(input logic [3:0] e, input logic inv);
        param_end = e;
        param_inv = inv;
        start     = 1'b1;
        tick();
        start_cyc = cyc;
        start     = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle: timeout after %0d cycles, %0d events still expected", n, q.size());
        end
        repeat (4) tick();
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Slave model: acks after 0 (or random 0..5) wait cycles, may stall a
    // chosen address, and in random mode throws spurious acks while stb=0.
    initial begin
        ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ack = 1'b0;
            if (stb) begin
                if (stall_en && adr == stall_adr) begin
                end else if (dly == 0) begin
                    ack = 1'b1;
                    dly = rand_mode ? int'($urandom_range(0, 5)) : 0;
                end else begin
                    dly--;
                end
            end else if (rand_mode) begin
                ack = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Monitor / scoreboard
    logic        prev_wait = 1'b0;
    logic        ack_d1 = 1'b0;
    logic        ack_d2 = 1'b0;
    logic [7:0]  prev_adr;
    logic [31:0] prev_dat;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_wait = 1'b0;
            ack_d1    = 1'b0;
            ack_d2    = 1'b0;
        end else begin
            if (prev_wait && stb) check("stable_adr_dat", {adr, dat}, {prev_adr, prev_dat});
            if (ack_d1) check("gap_stb_low", 64'(stb), 64'd0);
            if (ack_d2) check("gap_one_cycle", 64'(stb | done), 64'd1);
            if (stb && ack) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: adr 0x%0h dat 0x%0h, expected no traffic", adr, dat);
                end else begin
                    e = q.pop_front();
                    check("write", {1'b0, adr, dat, we, sel}, {e.is_done, e.adr, e.dat, 1'b1, 4'hf});
                end
            end
            if (done) begin
                done_cyc = cyc;
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: done=1, expected no completion");
                end else begin
                    e = q.pop_front();
                    check("done", {1'b1, busy, stb}, {e.is_done, 1'b0, 1'b0});
                end
            end
            ack_d2    = ack_d1;
            ack_d1    = stb && ack;
            prev_wait = stb && !ack;
            prev_adr  = adr;
            prev_dat  = dat;
        end
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; param_end = '0; param_inv = 1'b0; frame_start = 1'b0;
        repeat (3) tick();
        check("reset_state", {busy, done, stb, we, sel, adr, dat}, 64'd0);
        reset = 1'b0;
        tick();

        // 1: full table, zero-wait ack, latency 2*(14+3)
        push_seq(14, 1'b0);
        do_start(4'd14, 1'b0);
        check("busy_after_start", 64'(busy), 64'd1);
        wait_idle(200);
        check("done_latency", 64'(done_cyc - start_cyc), 64'd34);

        // 2: random ack delay and spurious acks while stb=0
        rand_mode = 1'b1;
        push_seq(5, 1'b1);
        do_start(4'd5, 1'b1);
        wait_idle(400);
        rand_mode = 1'b0;
        dly = 0;

        // 3: single entry, start pulses while busy are ignored
        push_seq(0, 1'b0);
        do_start(4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            param_end = 4'd7;
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        wait_idle(100);

        // 4: reset during the 5th table write, then restart from entry 0
        stall_adr = 8'h44;
        stall_en  = 1'b1;
        for (int i = 0; i <= 3; i++) push_w(8'h40 + 8'(i), exp_tbl[i]);
        do_start(4'd9, 1'b0);
        n = 0;
        while (!(stb && adr == 8'h44) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            n_vec++;
            n_err++;
            $display("FAIL stall_wait: 5th write never reached the bus");
        end
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("rst_mid_stb", 64'(stb), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_queue", 64'(q.size()), 64'd0);
        reset    = 1'b0;
        stall_en = 1'b0;
        tick();
        push_seq(3, 1'b1);
        do_start(4'd3, 1'b1);
        wait_idle(100);

        // 5: frame_start behaviour
`ifdef JELLY_VIDEO_TBL_MODULATOR_CTL_INV_TOGGLE_EN
        push_seq(1, 1'b1);
        do_start(4'd1, 1'b1);
        wait_idle(100);
        push_w(8'h05, 32'd0);
        push_done();
        pulse_fs();
        wait_idle(100);
        push_seq(2, 1'b1);
        push_w(8'h05, 32'd0);
        push_done();
        do_start(4'd2, 1'b1);
        tick();
        pulse_fs();
        tick();
        pulse_fs();
        wait_idle(100);
`else
        pulse_fs();
        tick();
        pulse_fs();
        repeat (20) tick();
        check("fs_ignored_busy", 64'(busy), 64'd0);
`endif

        check("queue_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
